// File: rtl/tcdm_mem_responder.sv
// tcdm_mem_responder: single-ported TCDM memory model shared by N_PORTS initiators.
//   clk_i, rst_ni        clock, async active-low reset
//   stall_i              suppresses all grants for the cycle (arbiter pointer holds)
//   tcdm_req_i/gnt_o     per-port request / combinational round-robin grant
//   tcdm_add_i/wen_i/be_i/data_i  per-port address, 1=read, byte enables, write data
//   tcdm_r_valid_o/r_data_o       per-port response, one cycle after grant
//   err_o / err_clr_i    sticky out-of-range flag / synchronous clear

// Per-port response register: fires one cycle after its port was granted and
// keeps the last returned word while idle.
module tcdm_resp_lane (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        hit,
  input  logic [31:0] rdata,
  output logic        r_valid,
  output logic [31:0] r_data
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= 32'h0;
    end else begin
      r_valid <= hit;
      if (hit) r_data <= rdata;
    end
  end
endmodule

module tcdm_mem_responder #(
  parameter int unsigned N_PORTS   = 2,
  parameter int unsigned MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h1C000000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     stall_i,
  input  logic [N_PORTS-1:0]       tcdm_req_i,
  output logic [N_PORTS-1:0]       tcdm_gnt_o,
  input  logic [N_PORTS-1:0][31:0] tcdm_add_i,
  input  logic [N_PORTS-1:0]       tcdm_wen_i,
  input  logic [N_PORTS-1:0][3:0]  tcdm_be_i,
  input  logic [N_PORTS-1:0][31:0] tcdm_data_i,
  output logic [N_PORTS-1:0]       tcdm_r_valid_o,
  output logic [N_PORTS-1:0][31:0] tcdm_r_data_o,
  output logic                     err_o,
  input  logic                     err_clr_i
);
  localparam int unsigned PW   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned AW   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] SPAN = 33'(MEM_WORDS) * 33'd4;

  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
  } tcdm_req_t;

  logic [PW-1:0] rr_q, rr_d;
  logic [PW-1:0] gnt_idx;
  logic          gnt_any;
  logic [N_PORTS-1:0] gnt;
  tcdm_req_t     sel;
  logic [31:0]   off;
  logic [AW-1:0] widx;
  logic          in_range;
  logic [31:0]   rdata;
  logic [31:0]   mem [MEM_WORDS];

  // Round-robin search starting at rr_q; reset also kills grants so nothing
  // is accepted while the responder is held in reset.
  always_comb begin
    int p;
    p       = 0;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < int'(N_PORTS); i++) begin
      p = int'(rr_q) + i;
      if (p >= int'(N_PORTS)) p = p - int'(N_PORTS);
      if (!gnt_any && tcdm_req_i[p] && !stall_i && rst_ni) begin
        gnt[p]  = 1'b1;
        gnt_any = 1'b1;
        gnt_idx = PW'(p);
      end
    end
  end

  assign tcdm_gnt_o = gnt;

  always_comb begin
    int nxt;
    nxt  = int'(gnt_idx) + 1;
    if (nxt >= int'(N_PORTS)) nxt = 0;
    rr_d = gnt_any ? PW'(nxt) : rr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= '0;
    else         rr_q <= rr_d;
  end

  // Only the granted port reaches the memory, so a single mux feeds it.
  assign sel.add  = tcdm_add_i[gnt_idx];
  assign sel.wen  = tcdm_wen_i[gnt_idx];
  assign sel.be   = tcdm_be_i[gnt_idx];
  assign sel.data = tcdm_data_i[gnt_idx];

  // Both bounds are needed: an address below BASE wraps to a large offset,
  // but not necessarily one beyond SPAN for every BASE/size combination.
  assign off      = sel.add - BASE_ADDR;
  assign in_range = (sel.add >= BASE_ADDR) && ({1'b0, off} < SPAN);
  assign widx     = off[AW+1:2];

  // Memory contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (gnt_any && !sel.wen && in_range) begin
      for (int b = 0; b < 4; b++)
        if (sel.be[b]) mem[widx][8*b +: 8] <= sel.data[8*b +: 8];
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (sel.wen) rdata = in_range ? mem[widx] : 32'hDEADBEEF;
  end

  for (genvar g = 0; g < int'(N_PORTS); g++) begin : g_lane
    tcdm_resp_lane u_lane (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .hit     (gnt[g]),
      .rdata   (rdata),
      .r_valid (tcdm_r_valid_o[g]),
      .r_data  (tcdm_r_data_o[g])
    );
  end

  // A new error beats a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     err_o <= 1'b0;
    else if (gnt_any && !in_range)   err_o <= 1'b1;
    else if (err_clr_i)              err_o <= 1'b0;
  end
endmodule

// File: tb/tb_tcdm_mem_responder.sv
module tb_tcdm_mem_responder;
  localparam logic [31:0] BASE = 32'h1C000000;

  logic             clk = 1'b0;
  logic             rst_ni, stall, err_clr, err;
  logic [1:0]       req, gnt, wen, rv;
  logic [1:0][31:0] add, wdata, rdata;
  logic [1:0][3:0]  be;
  int errors = 0;
  int checks = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  tcdm_mem_responder #(.N_PORTS(2), .MEM_WORDS(256), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .stall_i(stall),
    .tcdm_req_i(req), .tcdm_gnt_o(gnt), .tcdm_add_i(add), .tcdm_wen_i(wen),
    .tcdm_be_i(be), .tcdm_data_i(wdata), .tcdm_r_valid_o(rv), .tcdm_r_data_o(rdata),
    .err_o(err), .err_clr_i(err_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int p, input logic [31:0] a, input logic w,
                     input logic [3:0] b, input logic [31:0] d);
    add[p] = a; wen[p] = w; be[p] = b; wdata[p] = d;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst_ni = 1'b0; stall = 1'b0; err_clr = 1'b0; req = 2'b11;
    drv(0, BASE, 1'b1, 4'hF, 32'h0);
    drv(1, BASE + 32'h8, 1'b1, 4'hF, 32'h0);

    // Reset state with both ports requesting: grants forced off
    smp();
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_rvalid", 64'(rv), 64'h0);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    tick();
    rst_ni = 1'b1;

    // Continuous requests from reset: alternate 0,1,... with response one cycle later
    for (int k = 0; k < 8; k++) begin
      smp();
      chk($sformatf("rr_gnt%0d", k), 64'(gnt), (k % 2 == 0) ? 64'h1 : 64'h2);
      chk($sformatf("rr_rv%0d", k), 64'(rv), (k == 0) ? 64'h0 : ((k % 2 == 1) ? 64'h1 : 64'h2));
      pulses += int'(rv[0]) + int'(rv[1]);
      tick();
    end
    req = 2'b00;
    smp();
    chk("rr_idle_gnt", 64'(gnt), 64'h0);
    chk("rr_last_rv", 64'(rv), 64'h2);
    pulses += int'(rv[0]) + int'(rv[1]);
    tick();
    smp();
    chk("rr_drain_rv", 64'(rv), 64'h0);
    chk("rr_pulses", 64'(pulses), 64'd8);

    // Full-word write then read on port 0 (pointer is back at 0)
    tick();
    req = 2'b01; drv(0, BASE, 1'b0, 4'hF, 32'hA5A5_1234);
    smp();
    chk("wr_gnt", 64'(gnt), 64'h1);
    tick();
    drv(0, BASE, 1'b1, 4'hF, 32'h0);
    smp();
    chk("rd_gnt", 64'(gnt), 64'h1);
    chk("wr_rv", 64'(rv), 64'h1);
    chk("wr_rdata", 64'(rdata[0]), 64'h0);
    tick();
    req = 2'b00;
    smp();
    chk("rd_rv", 64'(rv), 64'h1);
    chk("rd_rdata", 64'(rdata[0]), 64'hA5A5_1234);

    // Byte-enable merge on port 1
    tick();
    req = 2'b10; drv(1, BASE + 32'h4, 1'b0, 4'hF, 32'hFFFF_FFFF);
    smp();
    chk("pre_gnt", 64'(gnt), 64'h2);
    tick();
    drv(1, BASE + 32'h4, 1'b0, 4'b0101, 32'h0000_0000);
    smp();
    chk("be_gnt", 64'(gnt), 64'h2);
    tick();
    drv(1, BASE + 32'h4, 1'b1, 4'hF, 32'h0);
    tick();
    req = 2'b00;
    smp();
    chk("be_rv", 64'(rv), 64'h2);
    chk("be_rdata", 64'(rdata[1]), 64'hFF00_FF00);
    tick();
    smp();
    chk("hold_rv", 64'(rv), 64'h0);
    chk("hold_rdata", 64'(rdata[1]), 64'hFF00_FF00);

    // Stall for three cycles with both requesting; pointer is at 0
    tick();
    stall = 1'b1; req = 2'b11;
    drv(0, BASE, 1'b1, 4'hF, 32'h0);
    drv(1, BASE + 32'h4, 1'b1, 4'hF, 32'h0);
    for (int k = 0; k < 3; k++) begin
      smp();
      chk($sformatf("stall_gnt%0d", k), 64'(gnt), 64'h0);
      tick();
    end
    smp();
    chk("stall_rv", 64'(rv), 64'h0);
    tick();
    stall = 1'b0;
    smp();
    chk("unstall_gnt0", 64'(gnt), 64'h1);
    tick();
    smp();
    chk("unstall_gnt1", 64'(gnt), 64'h2);
    tick();
    req = 2'b00;

    // Out-of-range read on port 1, then clear
    drv(1, 32'h1C00_0400, 1'b1, 4'hF, 32'h0);
    req = 2'b10;
    smp();
    chk("oor_gnt", 64'(gnt), 64'h2);
    chk("oor_err_before", 64'(err), 64'h0);
    tick();
    req = 2'b00;
    smp();
    chk("oor_rv", 64'(rv), 64'h2);
    chk("oor_rdata", 64'(rdata[1]), 64'hDEAD_BEEF);
    chk("oor_err", 64'(err), 64'h1);
    tick();
    err_clr = 1'b1;
    smp();
    chk("clr_pending", 64'(err), 64'h1);
    tick();
    err_clr = 1'b0;
    smp();
    chk("clr_done", 64'(err), 64'h0);

    // Last in-range word works and raises no error
    tick();
    req = 2'b01; drv(0, 32'h1C00_03FC, 1'b0, 4'hF, 32'h1234_5678);
    tick();
    drv(0, 32'h1C00_03FC, 1'b1, 4'hF, 32'h0);
    tick();
    req = 2'b00;
    smp();
    chk("top_rdata", 64'(rdata[0]), 64'h1234_5678);
    chk("top_err", 64'(err), 64'h0);

    // Out-of-range write below BASE coinciding with clear: set wins
    tick();
    req = 2'b01; err_clr = 1'b1; drv(0, 32'h1BFF_FFFC, 1'b0, 4'hF, 32'h0);
    tick();
    req = 2'b00; err_clr = 1'b0;
    smp();
    chk("setwins_err", 64'(err), 64'h1);
    chk("oorwr_rdata", 64'(rdata[0]), 64'h0);

    // Reset in the cycle after a grant drops the response
    tick();
    req = 2'b01; drv(0, BASE, 1'b1, 4'hF, 32'h0);
    tick();
    rst_ni = 1'b0; req = 2'b11;
    smp();
    chk("mid_rst_rv", 64'(rv), 64'h0);
    chk("mid_rst_rdata", rdata, 64'h0);
    chk("mid_rst_err", 64'(err), 64'h0);
    chk("mid_rst_gnt", 64'(gnt), 64'h0);
    tick();
    rst_ni = 1'b1; req = 2'b00;
    smp();
    chk("post_rst_rv", 64'(rv), 64'h0);
    tick();
    req = 2'b01;
    smp();
    chk("post_rst_gnt", 64'(gnt), 64'h1);
    tick();
    req = 2'b00;
    smp();
    chk("post_rst_rdata", 64'(rdata[0]), 64'hA5A5_1234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tcdm_mem_responder.md
TCDM_MEM_RESPONDER -- requirements
Module: tcdm_mem_responder

Interface
REQ-001 The block SHALL have parameter N_PORTS, default 2, giving the number of TCDM initiator ports.
REQ-002 The block SHALL have parameter MEM_WORDS, default 256, giving the number of 32-bit memory words (power of two).
REQ-003 The block SHALL have parameter BASE_ADDR, default 32'h1C000000, giving the byte address of word 0.
REQ-004 The block SHALL have these ports:
- clk_i  in  1  sole clock; all state on its rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- stall_i  in  1  when 1, no grant is issued this cycle.
- tcdm_req_i  in  N_PORTS  per-port request.
- tcdm_gnt_o  out  N_PORTS  per-port grant.
- tcdm_add_i  in  N_PORTS x 32  per-port byte address.
- tcdm_wen_i  in  N_PORTS  per-port 1=read, 0=write.
- tcdm_be_i  in  N_PORTS x 4  per-port byte enables.
- tcdm_data_i  in  N_PORTS x 32  per-port write data.
- tcdm_r_valid_o  out  N_PORTS  per-port response valid.
- tcdm_r_data_o  out  N_PORTS x 32  per-port read data.
- err_o  out  1  sticky out-of-range access flag.
- err_clr_i  in  1  synchronous clear of err_o.

Function
REQ-005 The block SHALL model a single-ported memory: at most one tcdm_gnt_o bit SHALL be 1 per cycle.
REQ-006 tcdm_gnt_o SHALL be combinational from tcdm_req_i, stall_i and the round-robin pointer; a grant SHALL only be issued to a port with tcdm_req_i=1.
REQ-007 With stall_i=1, all tcdm_gnt_o bits SHALL be 0 and the pointer SHALL hold.
REQ-008 Arbitration SHALL be round-robin: search starts at port rr_q and ascends with wrap; after granting port k, rr_q SHALL become (k+1) mod N_PORTS; with no grant rr_q SHALL hold.
REQ-009 A transaction SHALL complete in the cycle req=1 and gnt=1; the initiator holds add/wen/be/data stable until then.
REQ-010 Word index SHALL be (add - BASE_ADDR) >> 2; an address is in range iff BASE_ADDR <= add < BASE_ADDR + 4*MEM_WORDS; add[1:0] SHALL be ignored.
REQ-011 A granted in-range write SHALL update only bytes whose be bit is 1, at the edge ending the grant cycle.
REQ-012 A granted in-range read SHALL return the word content before any same-cycle write (none possible under REQ-005).
REQ-013 Exactly one cycle after every grant, read or write, tcdm_r_valid_o of the granted port SHALL be 1 for one cycle; all other r_valid bits SHALL be 0.
REQ-014 tcdm_r_data_o of the responding port SHALL carry read data in the r_valid cycle; it SHALL be 32'h0 after writes and SHALL hold its last value when r_valid=0.
REQ-015 An out-of-range access SHALL still be granted and answered: writes change nothing; reads return 32'hDEADBEEF; err_o SHALL be set the following cycle.
REQ-016 err_o SHALL stay 1 until err_clr_i=1; if clear and a new error coincide, set SHALL win.
REQ-017 Back-to-back grants to the same or different ports SHALL be sustained at one per cycle with no bubble.
REQ-018 A request that is withdrawn before grant SHALL leave no state change (initiator protocol violation; undefined beyond that).

Reset
REQ-019 While rst_ni=0: rr_q=0; tcdm_r_valid_o=0; tcdm_r_data_o=0; err_o=0; tcdm_gnt_o SHALL be forced to 0.
REQ-020 Memory contents SHALL NOT be reset; reset mid-transaction SHALL drop any pending response (no r_valid after release).

Verification
REQ-021 Port 0 writes 32'hA5A5_1234 to 32'h1C000000 with be=4'hF, then reads it -> gnt in request cycle, r_valid one cycle after each grant, read data 32'hA5A5_1234.
REQ-022 Preload 32'hFFFF_FFFF at 32'h1C000004; write 32'h0000_0000 with be=4'b0101; read -> 32'hFF00_FF00.
REQ-023 Both ports request continuously for 8 cycles from reset -> grants alternate 0,1,0,1,...; exactly 8 r_valid pulses, one cycle after each grant.
REQ-024 stall_i=1 for 3 cycles with both ports requesting -> no gnt, rr_q unchanged; on release port 0 is granted first.
REQ-025 Port 1 reads 32'h1C000400 (MEM_WORDS=256) -> granted, r_data 32'hDEADBEEF, err_o=1 next cycle; err_clr_i pulse -> err_o=0.
REQ-026 Assert rst_ni=0 in the cycle after a grant -> no r_valid emitted, all outputs at REQ-019 values; previously written word still readable after release.
